uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 33 +++
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host/framer-side signal bundle for uart_tx_fifo.
// LEVEL only exists when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              WR_EN;
    logic [DATA_W-1:0] WR_DATA;
    logic              OVF_CLR;
    logic              busy;
    logic              FULL;
    logic              EMPTY;
    logic              OVERFLOW;
    logic              transmit;
    logic [DATA_W-1:0] TX_DATA;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [AW:0]       LEVEL;
`endif

`ifdef UART_TX_FIFO_LEVEL_EN
    modport master (output WR_EN, WR_DATA, OVF_CLR, busy,
                    input  FULL, EMPTY, OVERFLOW, transmit, TX_DATA, LEVEL);
    modport slave  (input  WR_EN, WR_DATA, OVF_CLR, busy,
                    output FULL, EMPTY, OVERFLOW, transmit, TX_DATA, LEVEL);
`else
    modport master (output WR_EN, WR_DATA, OVF_CLR, busy,
                    input  FULL, EMPTY, OVERFLOW, transmit, TX_DATA);
    modport slave  (input  WR_EN, WR_DATA, OVF_CLR, busy,
                    output FULL, EMPTY, OVERFLOW, transmit, TX_DATA);
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Character FIFO feeding a UART TX framer through a transmit/busy launch handshake.
// Optional LEVEL occupancy output enabled by defining UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_fifo_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FullCnt = DEPTH[AW:0];
    localparam logic [AW:0]   CntOne  = 1;
    localparam logic [AW-1:0] PtrOne  = 1;

    typedef enum logic [1:0] {StIdle = 2'b00, StReq = 2'b01, StSend = 2'b10} state_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q;
    logic              ovf_q;
    logic              transmit_q;
    logic [DATA_W-1:0] tx_data_q;
    state_e            state_q;

    logic full, empty, push, pop;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign push  = bus.WR_EN & ~full;
    // Pops only from IDLE, which also enforces the gap after busy falls.
    assign pop   = (state_q == StIdle) & ~empty & ~bus.busy;

    always_ff @(posedge CLK) begin
        if (push) mem[wptr_q] <= bus.WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrOne;
            if (pop)  rptr_q <= rptr_q + PtrOne;
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
            // A dropped write wins over a simultaneous clear.
            if (bus.WR_EN && full) ovf_q <= 1'b1;
            else if (bus.OVF_CLR)  ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            transmit_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    transmit_q <= 1'b0;
                    if (pop) begin
                        state_q    <= StReq;
                        transmit_q <= 1'b1;
                        tx_data_q  <= mem[rptr_q];
                    end
                end
                StReq: begin
                    transmit_q <= 1'b1;
                    if (bus.busy) begin
                        transmit_q <= 1'b0;
                        state_q    <= StSend;
                    end
                end
                StSend: begin
                    transmit_q <= 1'b0;
                    if (!bus.busy) state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    transmit_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.FULL     = full;
    assign bus.EMPTY    = empty;
    assign bus.OVERFLOW = ovf_q;
    assign bus.transmit = transmit_q;
    assign bus.TX_DATA  = tx_data_q;
`ifdef UART_TX_FIFO_LEVEL_EN
    assign bus.LEVEL    = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected characters, a monitor
// checks each transmit launch, and a framer model drives busy.
module tb_uart_tx_fifo;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_tx_fifo_if #(.DATA_W(8), .DEPTH(8)) bus ();

    uart_tx_fifo #(.DATA_W(8), .DEPTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    logic busy_force = 1'b0;
    logic busy_fr    = 1'b0;
    assign bus.busy = busy_force | busy_fr;

    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    bit framer_en = 1'b0;
    int fr_dly  = 3;
    int fr_hold = 20;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Checks every transmit rising edge against the head of the scoreboard.
    task automatic monitor_loop();
        logic tr_prev = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (!RST) tr_prev = 1'b0;
            else begin
                if (bus.transmit && !tr_prev) begin
                    if (exp_q.size() == 0) check("spurious_launch", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("tx_data", {24'd0, bus.TX_DATA}, {24'd0, e});
                    end
                end
                tr_prev = bus.transmit;
            end
        end
    endtask

    // Framer model: raise busy fr_dly cycles after a request, hold fr_hold cycles.
    task automatic framer_loop();
        int pending;
        forever begin
            @(negedge CLK);
            if (framer_en && RST && bus.transmit && !busy_fr) begin
                repeat (fr_dly) @(posedge CLK);
                #1 busy_fr = 1'b1;
                @(negedge CLK);
                check("req_held", {31'd0, bus.transmit}, 32'd1);
                @(negedge CLK);
                check("req_drop_after_busy", {31'd0, bus.transmit}, 32'd0);
                repeat (fr_hold) @(posedge CLK);
                #1 busy_fr = 1'b0;
                pending = exp_q.size();
                @(negedge CLK);
                @(negedge CLK);
                check("no_early_relaunch", {31'd0, bus.transmit}, 32'd0);
                @(negedge CLK);
                if (pending > 0) check("relaunch_gap", {31'd0, bus.transmit}, 32'd1);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [7:0] d, input bit accepted);
        bus.WR_EN   = 1'b1;
        bus.WR_DATA = d;
        if (accepted) exp_q.push_back(d);
        @(negedge CLK);
        bus.WR_EN = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.WR_EN   = 1'b0;
        bus.WR_DATA = '0;
        bus.OVF_CLR = 1'b0;
        fork
            monitor_loop();
            framer_loop();
        join_none

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_transmit", {31'd0, bus.transmit}, 32'd0);
        check("rst_txdata",   {24'd0, bus.TX_DATA},  32'd0);
        check("rst_empty",    {31'd0, bus.EMPTY},    32'd1);
        check("rst_full",     {31'd0, bus.FULL},     32'd0);
        check("rst_ovf",      {31'd0, bus.OVERFLOW}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Single write latency: launch two edges after the write edge
        wr(8'hA5, 1'b1);
        check("latency_not_early", {31'd0, bus.transmit}, 32'd0);
        @(negedge CLK);
        check("latency_transmit", {31'd0, bus.transmit}, 32'd1);
        check("latency_txdata",   {24'd0, bus.TX_DATA},  32'h0000_00A5);
        check("empty_after_pop",  {31'd0, bus.EMPTY},    32'd1);
        busy_force = 1'b1;
        @(negedge CLK);
        check("send_transmit_low", {31'd0, bus.transmit}, 32'd0);
        busy_force = 1'b0;
        repeat (2) @(negedge CLK);

        // Three back-to-back writes through the framer model
        fr_dly = 3; fr_hold = 20; framer_en = 1'b1;
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        wait_drain(300);
        repeat (40) @(negedge CLK);
        framer_en = 1'b0;

        // Fill with busy held, ninth write dropped
        busy_force = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i), 1'b1);
        check("full_after_8",   {31'd0, bus.FULL},     32'd1);
        check("no_ovf_yet",     {31'd0, bus.OVERFLOW}, 32'd0);
        wr(8'h48, 1'b0);
        check("ovf_after_9",    {31'd0, bus.OVERFLOW}, 32'd1);
        check("still_full",     {31'd0, bus.FULL},     32'd1);
        bus.OVF_CLR = 1'b1;
        @(negedge CLK);
        bus.OVF_CLR = 1'b0;
        check("ovf_cleared",    {31'd0, bus.OVERFLOW}, 32'd0);

        // Pop and write on the same edge while full: write dropped, one slot frees
        busy_force = 1'b0;
        wr(8'h99, 1'b0);
        busy_force = 1'b1;
        check("pop_wr_ovf",      {31'd0, bus.OVERFLOW}, 32'd1);
        check("pop_wr_not_full", {31'd0, bus.FULL},     32'd0);
        check("pop_wr_transmit", {31'd0, bus.transmit}, 32'd1);
        @(negedge CLK);
        fr_dly = 1; fr_hold = 2; framer_en = 1'b1;
        busy_force = 1'b0;
        wait_drain(400);
        for (int i = 0; i < 10; i++) begin
            wr(8'h60 + 8'(i), 1'b1);
            repeat (2) @(negedge CLK);
        end
        wait_drain(400);
        repeat (15) @(negedge CLK);
        framer_en = 1'b0;
        repeat (5) @(negedge CLK);

        // Reset while in SEND with four entries queued
        for (int i = 0; i < 5; i++) wr(8'h70 + 8'(i), 1'b1);
        busy_force = 1'b1;
        @(negedge CLK);
        check("pre_rst_send",  {31'd0, bus.transmit}, 32'd0);
        check("pre_rst_empty", {31'd0, bus.EMPTY},    32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("pre_rst_level", {28'd0, bus.LEVEL},    32'd4);
`endif
        #2 RST = 1'b0;
        #1;
        check("mid_rst_transmit", {31'd0, bus.transmit}, 32'd0);
        check("mid_rst_txdata",   {24'd0, bus.TX_DATA},  32'd0);
        check("mid_rst_empty",    {31'd0, bus.EMPTY},    32'd1);
        check("mid_rst_ovf",      {31'd0, bus.OVERFLOW}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        check("mid_rst_level",    {28'd0, bus.LEVEL},    32'd0);
`endif
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        busy_force = 1'b0;
        repeat (5) @(negedge CLK);
        check("post_rst_idle",  {31'd0, bus.transmit}, 32'd0);
        check("post_rst_empty", {31'd0, bus.EMPTY},    32'd1);

        // Block accepts new work after reset
        wr(8'h5A, 1'b1);
        wait_drain(10);
        check("final_transmit", {31'd0, bus.transmit}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
